bcd_time_counter: RTL and testbench

- Parametrised successor to the two-field MM:SS stopwatch counter.
- Counts FIELDS base-60 BCD fields; field 0 is seconds, and the top field wraps at TOP_MAX.
- Counts on an external one-cycle tick and is driven by an explicit RUN/PAUSED/ADJUST state machine, with per-digit clamped load.
- Sits between the tick divider / debouncers and the 7-segment display mux.

---
 rtl/bcd_time_counter.sv | 187 ++++++++++++++++++
 tb/tb_bcd_time_counter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_time_counter.sv
// Multi-field base-60 BCD time counter (MM:SS / HH:MM:SS) with RUN/PAUSED/ADJUST control and clamped digit load.
// Optional down counting is enabled by defining BCD_TIME_COUNTER_DOWN_EN.
module bcd_time_counter #(
    parameter int FIELDS  = 2,
    parameter int TOP_MAX = 59,
    parameter int SELW    = 3
) (
    input  logic                  clk_c,
    input  logic                  reset_c,
    input  logic                  tick,
    input  logic                  pause_c,
    input  logic                  adj,
    input  logic [SELW-1:0]       sel,
    input  logic [3:0]            num,
    input  logic                  load,
    input  logic                  dir,
    output logic [8*FIELDS-1:0]   digits,
    output logic                  running,
    output logic                  wrap
);
    localparam int NDIG = 2 * FIELDS;
    localparam int TOPF = FIELDS - 1;
    localparam logic [3:0] TOP_T = 4'(TOP_MAX / 10);
    localparam logic [3:0] TOP_O = 4'(TOP_MAX % 10);

    typedef enum logic [1:0] {ST_PAUSED, ST_RUN, ST_ADJUST} state_t;

    state_t              state_q, state_d;
    logic [8*FIELDS-1:0] digits_q, digits_d;
    logic                wrap_q, wrap_d;
    logic                running_q, running_d;
    logic [8*FIELDS-1:0] up_val, nxt_val;
    logic                up_wrap, nxt_wrap;
    logic                count_en;
    logic [3:0]          dmax;

    // Increment: whole carry chain resolves in one cycle.
    always_comb begin
        logic [3:0] o, t;
        logic       c;
        up_val = digits_q;
        c      = 1'b1;
        for (int f = 0; f < FIELDS; f++) begin
            o = digits_q[8*f +: 4];
            t = digits_q[8*f+4 +: 4];
            if (c) begin
                if (f == TOPF) begin
                    if (o == TOP_O && t == TOP_T) begin
                        o = 4'd0;
                        t = 4'd0;
                    end else if (o == 4'd9) begin
                        o = 4'd0;
                        t = t + 4'd1;
                        c = 1'b0;
                    end else begin
                        o = o + 4'd1;
                        c = 1'b0;
                    end
                end else if (o != 4'd9) begin
                    o = o + 4'd1;
                    c = 1'b0;
                end else begin
                    o = 4'd0;
                    if (t == 4'd5) begin
                        t = 4'd0;
                    end else begin
                        t = t + 4'd1;
                        c = 1'b0;
                    end
                end
            end
            up_val[8*f +: 4]   = o;
            up_val[8*f+4 +: 4] = t;
        end
        up_wrap = c;
    end

`ifdef BCD_TIME_COUNTER_DOWN_EN
    logic [8*FIELDS-1:0] dn_val;
    logic                dn_wrap;

    always_comb begin
        logic [3:0] o, t;
        logic       b;
        dn_val = digits_q;
        b      = 1'b1;
        for (int f = 0; f < FIELDS; f++) begin
            o = digits_q[8*f +: 4];
            t = digits_q[8*f+4 +: 4];
            if (b) begin
                if (f == TOPF) begin
                    // Borrow only reaches the top field when every lower field is zero.
                    if (o == 4'd0 && t == 4'd0) begin
                        o = TOP_O;
                        t = TOP_T;
                    end else if (o == 4'd0) begin
                        o = 4'd9;
                        t = t - 4'd1;
                        b = 1'b0;
                    end else begin
                        o = o - 4'd1;
                        b = 1'b0;
                    end
                end else if (o != 4'd0) begin
                    o = o - 4'd1;
                    b = 1'b0;
                end else begin
                    o = 4'd9;
                    if (t == 4'd0) begin
                        t = 4'd5;
                    end else begin
                        t = t - 4'd1;
                        b = 1'b0;
                    end
                end
            end
            dn_val[8*f +: 4]   = o;
            dn_val[8*f+4 +: 4] = t;
        end
        dn_wrap = b;
    end

    assign nxt_val  = dir ? dn_val  : up_val;
    assign nxt_wrap = dir ? dn_wrap : up_wrap;
`else
    logic dir_unused;
    assign dir_unused = dir;
    assign nxt_val    = up_val;
    assign nxt_wrap   = up_wrap;
`endif

    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        wrap_d   = 1'b0;
        dmax     = 4'd9;

        if (adj)
            state_d = ST_ADJUST;
        else if (state_q == ST_ADJUST)
            state_d = ST_PAUSED;
        else if (pause_c)
            state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;

        count_en = (state_q == ST_RUN) && tick && !adj;

        if (count_en) begin
            digits_d = nxt_val;
            wrap_d   = nxt_wrap;
        end else if (state_q == ST_ADJUST && load && int'(sel) < NDIG) begin
            for (int i = 0; i < NDIG; i++) begin
                if (int'(sel) == i) begin
                    if (i % 2 == 0)
                        dmax = 4'd9;
                    else if (i / 2 == TOPF)
                        dmax = TOP_T;
                    else
                        dmax = 4'd5;
                    digits_d[4*i +: 4] = (num > dmax) ? dmax : num;
                end
            end
            // Pull an over-range top field back to TOP_MAX in the same edge.
            if (digits_d[8*TOPF+4 +: 4] == TOP_T && digits_d[8*TOPF +: 4] > TOP_O)
                digits_d[8*TOPF +: 4] = TOP_O;
        end

        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk_c or posedge reset_c) begin
        if (reset_c) begin
            state_q   <= ST_PAUSED;
            digits_q  <= '0;
            wrap_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            digits_q  <= digits_d;
            wrap_q    <= wrap_d;
            running_q <= running_d;
        end
    end

    assign digits  = digits_q;
    assign running = running_q;
    assign wrap    = wrap_q;
endmodule

// File: tb/tb_bcd_time_counter.sv
// Scoreboard bench for bcd_time_counter: MM:SS/59 and HH:MM:SS/23 instances share one stimulus stream.
module tb_bcd_time_counter;
    logic        clk = 1'b0;
    logic        reset_c, tick, pause_c, adj, load, dir;
    logic [2:0]  sel;
    logic [3:0]  num;
    logic [15:0] dig_a;
    logic        run_a, wrap_a;
    logic [23:0] dig_b;
    logic        run_b, wrap_b;

    always #5 clk = ~clk;

    bcd_time_counter #(.FIELDS(2), .TOP_MAX(59), .SELW(3)) u_dut_a (
        .clk_c(clk), .reset_c(reset_c), .tick(tick), .pause_c(pause_c), .adj(adj),
        .sel(sel), .num(num), .load(load), .dir(dir),
        .digits(dig_a), .running(run_a), .wrap(wrap_a));

    bcd_time_counter #(.FIELDS(3), .TOP_MAX(23), .SELW(3)) u_dut_b (
        .clk_c(clk), .reset_c(reset_c), .tick(tick), .pause_c(pause_c), .adj(adj),
        .sel(sel), .num(num), .load(load), .dir(dir),
        .digits(dig_b), .running(run_b), .wrap(wrap_b));

    typedef struct {
        string       name;
        int          dut;
        logic [31:0] dig;
        logic        run;
        logic        wr;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        m_e;
    logic [31:0] m_dig;
    logic        m_run, m_wr;
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic push(input string nm, input int d, input logic [31:0] v, input logic r, input logic w);
        exp_t e;
        e.name = nm; e.dut = d; e.dig = v; e.run = r; e.wr = w;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_pause();
        pause_c = 1'b1; step(); pause_c = 1'b0;
    endtask

    task automatic do_load(input logic [2:0] s, input logic [3:0] n);
        sel = s; num = n; load = 1'b1; step(); load = 1'b0;
    endtask

    // Monitor: drains pending expectations on every falling edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            m_e = exp_q.pop_front();
            if (m_e.dut == 0) begin
                m_dig = {16'h0, dig_a}; m_run = run_a; m_wr = wrap_a;
            end else begin
                m_dig = {8'h0, dig_b};  m_run = run_b; m_wr = wrap_b;
            end
            n_vec = n_vec + 1;
            if (m_dig !== m_e.dig || m_run !== m_e.run || m_wr !== m_e.wr) begin
                n_bad = n_bad + 1;
                $display("FAIL %s: got digits=%h running=%b wrap=%b, expected digits=%h running=%b wrap=%b",
                         m_e.name, m_dig, m_run, m_wr, m_e.dig, m_e.run, m_e.wr);
            end
        end
    end

    logic [31:0] a_hold, b_hold;

    initial begin
        reset_c = 1'b1; tick = 1'b0; pause_c = 1'b0; adj = 1'b0;
        load = 1'b0; dir = 1'b0; sel = '0; num = '0;
        step();
        push("reset_a", 0, 32'h0, 1'b0, 1'b0);
        push("reset_b", 1, 32'h0, 1'b0, 1'b0);
        reset_c = 1'b0;
        step();

        pulse_pause();
        push("start_run", 0, 32'h0, 1'b1, 1'b0);
        tick = 1'b1;
        repeat (60) step();
        push("sixty_ticks", 0, 32'h0100, 1'b1, 1'b0);
        step();
        tick = 1'b0;
        push("sixty_one_ticks", 0, 32'h0101, 1'b1, 1'b0);

        adj = 1'b1; step();
        push("enter_adjust", 0, 32'h0101, 1'b0, 1'b0);
        do_load(3'd3, 4'd5); do_load(3'd2, 4'd9); do_load(3'd1, 4'd9); do_load(3'd0, 4'd8);
        push("load_5958_clamped", 0, 32'h5958, 1'b0, 1'b0);
        push("b_load_low", 1, 32'h005958, 1'b0, 1'b0);
        adj = 1'b0; step();
        push("adjust_to_paused", 0, 32'h5958, 1'b0, 1'b0);
        tick = 1'b1; step(); tick = 1'b0;
        push("tick_in_paused", 0, 32'h5958, 1'b0, 1'b0);
        pulse_pause();
        push("resume", 0, 32'h5958, 1'b1, 1'b0);
        tick = 1'b1; step();
        push("to_5959", 0, 32'h5959, 1'b1, 1'b0);
        step(); tick = 1'b0;
        push("wrap_up", 0, 32'h0000, 1'b1, 1'b1);
        push("b_carry_top", 1, 32'h010000, 1'b1, 1'b0);
        step();
        push("wrap_one_cycle", 0, 32'h0000, 1'b1, 1'b0);

        adj = 1'b1; step();
        push("b_adjust", 1, 32'h010000, 1'b0, 1'b0);
        do_load(3'd5, 4'd9);
        push("b_top_tens_clamp", 1, 32'h210000, 1'b0, 1'b0);
        do_load(3'd4, 4'd9);
        push("b_top_ones_force", 1, 32'h230000, 1'b0, 1'b0);
        push("a_sel_out_of_range", 0, 32'h0000, 1'b0, 1'b0);
        do_load(3'd5, 4'd1); do_load(3'd4, 4'd9);
        push("b_top_19", 1, 32'h190000, 1'b0, 1'b0);
        do_load(3'd5, 4'd2);
        push("b_top_23_from_19", 1, 32'h230000, 1'b0, 1'b0);
        do_load(3'd3, 4'd5); do_load(3'd2, 4'd9); do_load(3'd1, 4'd5); do_load(3'd0, 4'd9);
        push("a_load_5959", 0, 32'h5959, 1'b0, 1'b0);
        push("b_load_235959", 1, 32'h235959, 1'b0, 1'b0);
        adj = 1'b0; step();
        pulse_pause();
        tick = 1'b1; step(); tick = 1'b0;
        push("a_wrap_again", 0, 32'h0000, 1'b1, 1'b1);
        push("b_wrap_top23", 1, 32'h000000, 1'b1, 1'b1);

        tick = 1'b1; repeat (5) step(); tick = 1'b0;
        push("at_0005", 0, 32'h0005, 1'b1, 1'b0);
        tick = 1'b1; pause_c = 1'b1; step(); tick = 1'b0; pause_c = 1'b0;
        push("tick_and_pause", 0, 32'h0006, 1'b0, 1'b0);
        push("b_tick_and_pause", 1, 32'h000006, 1'b0, 1'b0);
        tick = 1'b1; repeat (5) step(); tick = 1'b0;
        push("paused_ignores_ticks", 0, 32'h0006, 1'b0, 1'b0);
        pulse_pause();
        push("rerun", 0, 32'h0006, 1'b1, 1'b0);
        tick = 1'b1; adj = 1'b1; step(); tick = 1'b0;
        push("tick_and_adj", 0, 32'h0006, 1'b0, 1'b0);

        do_load(3'd0, 4'd0);
        push("load_zero", 0, 32'h0000, 1'b0, 1'b0);
        adj = 1'b0; step();
        pulse_pause();
        dir = 1'b1; tick = 1'b1; step();
`ifdef BCD_TIME_COUNTER_DOWN_EN
        push("down_underflow", 0, 32'h5959, 1'b1, 1'b1);
        push("b_down_underflow", 1, 32'h235959, 1'b1, 1'b1);
        step(); tick = 1'b0;
        push("down_step", 0, 32'h5958, 1'b1, 1'b0);
        a_hold = 32'h5958; b_hold = 32'h235958;
`else
        push("dir_ignored", 0, 32'h0001, 1'b1, 1'b0);
        push("b_dir_ignored", 1, 32'h000001, 1'b1, 1'b0);
        step(); tick = 1'b0;
        push("dir_ignored_2", 0, 32'h0002, 1'b1, 1'b0);
        a_hold = 32'h0002; b_hold = 32'h000002;
`endif
        dir = 1'b0;
        adj = 1'b1; step();
        do_load(3'd7, 4'd3);
        push("sel7_ignored", 0, a_hold, 1'b0, 1'b0);
        push("b_sel7_ignored", 1, b_hold, 1'b0, 1'b0);
        do_load(3'd6, 4'd3);
        push("b_sel6_ignored", 1, b_hold, 1'b0, 1'b0);

        do_load(3'd0, 4'd4); do_load(3'd1, 4'd3); do_load(3'd2, 4'd2); do_load(3'd3, 4'd1);
        push("load_1234", 0, 32'h1234, 1'b0, 1'b0);
        adj = 1'b0; step();
        pulse_pause();
        push("run_1234", 0, 32'h1234, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        reset_c = 1'b1;
        push("async_reset", 0, 32'h0000, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        reset_c = 1'b0;
        tick = 1'b1; repeat (3) step(); tick = 1'b0;
        push("ticks_after_reset", 0, 32'h0000, 1'b0, 1'b0);
        pulse_pause();
        push("run_after_reset", 0, 32'h0000, 1'b1, 1'b0);
        tick = 1'b1; step(); tick = 1'b0;
        push("count_after_reset", 0, 32'h0001, 1'b1, 1'b0);

        step(); step();
        if (exp_q.size() != 0) begin
            n_vec = n_vec + 1;
            n_bad = n_bad + 1;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
